// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: sweeps the NCO phase-step word from start_step to stop_step, holding each point dwell+1 clocks.
// Define SWEEP_TRIANGLE_EN to run back to start_step after reaching stop_step (triangle sweep).
module nco_sweep_ctrl #(
  parameter int LUT_LENGTH = 6,
  parameter int PHASE_BITWIDTH_FRACTIONAL = 2,
  parameter int STEP_W = LUT_LENGTH + PHASE_BITWIDTH_FRACTIONAL + 1,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [STEP_W-1:0]  start_step,
  input  logic [STEP_W-1:0]  stop_step,
  input  logic [STEP_W-2:0]  incr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [STEP_W-1:0]  step,
  output logic               step_valid,
  output logic               busy,
  output logic               done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic signed [STEP_W-1:0] cur, cur_n, start_r, start_n, stop_r, stop_n, tgt;
  logic [STEP_W-2:0] incr_r, incr_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n, cnt, cnt_n;
  logic back, back_n, valid_n, busy_n, done_n, turn;

  // One increment toward t, done one bit wider so it never wraps, clamped at t.
  function automatic logic signed [STEP_W-1:0] toward(input logic signed [STEP_W-1:0] c, t,
                                                      input logic [STEP_W-2:0] d);
    logic signed [STEP_W:0] ce, te, ie, up, dn;
    ce = $signed({c[STEP_W-1], c});
    te = $signed({t[STEP_W-1], t});
    ie = $signed({2'b00, d});
    up = ce + ie;
    dn = ce - ie;
    return te < ce ? (dn < te ? t : dn[STEP_W-1:0]) : (up > te ? t : up[STEP_W-1:0]);
  endfunction

  assign step = cur;

  always_comb begin
    state_n = state;
    cur_n = cur;
    start_n = start_r;
    stop_n = stop_r;
    incr_n = incr_r;
    dwell_n = dwell_r;
    cnt_n = cnt;
    back_n = back;
    valid_n = 1'b0;
    busy_n = busy;
    done_n = 1'b0;
    tgt = back ? start_r : stop_r;
`ifdef SWEEP_TRIANGLE_EN
    turn = !back && cur == stop_r && incr_r != '0 && start_r != stop_r;
`else
    turn = 1'b0;
`endif
    if (state == IDLE) begin
      if (start && !abort) begin
        state_n = RUN;
        start_n = $signed(start_step);
        stop_n = $signed(stop_step);
        incr_n = incr;
        dwell_n = dwell;
        cur_n = $signed(start_step);
        cnt_n = dwell;
        back_n = 1'b0;
        valid_n = 1'b1;
        busy_n = 1'b1;
      end
    end else if (abort) begin
      state_n = IDLE;
      busy_n = 1'b0;
      back_n = 1'b0;
    end else if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else begin
      cnt_n = dwell_r;
      if (turn) begin
        back_n = 1'b1;
        cur_n = toward(cur, start_r, incr_r);
        valid_n = 1'b1;
      end else if (cur != tgt && incr_r != '0) begin
        cur_n = toward(cur, tgt, incr_r);
        valid_n = 1'b1;
      end else if (!continuous) begin
        state_n = IDLE;
        done_n = 1'b1;
        busy_n = 1'b0;
        back_n = 1'b0;
      end else begin
        // A finished triangle leaves step at start_step, so go straight to the next point up.
        cur_n = back ? toward(cur, stop_r, incr_r) : start_r;
        back_n = 1'b0;
        valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      start_r <= '0;
      stop_r <= '0;
      incr_r <= '0;
      dwell_r <= '0;
      cnt <= '0;
      back <= 1'b0;
      step_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      start_r <= start_n;
      stop_r <= stop_n;
      incr_r <= incr_n;
      dwell_r <= dwell_n;
      cnt <= cnt_n;
      back <= back_n;
      step_valid <= valid_n;
      busy <= busy_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed vector table plus hand sequences for continuous, abort and reset cases.
module tb_nco_sweep_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic [8:0] start_step = '0, stop_step = '0, step;
  logic [7:0] incr = '0;
  logic [15:0] dwell = '0;
  logic step_valid, busy, done;
  int total = 0, passed = 0;

  nco_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
    .start_step(start_step), .stop_step(stop_step), .incr(incr), .dwell(dwell),
    .step(step), .step_valid(step_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ss, sp, inc, dw, poke, n;
    int pts[10];
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k);
    vec_t v = vecs[k];
    int np = 0, last = 0, lastpt = 0;
    bit got_done = 0;
    start_step = v.ss[8:0];
    stop_step = v.sp[8:0];
    incr = v.inc[7:0];
    dwell = v.dw[15:0];
    continuous = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk($sformatf("v%0d first_valid", k), int'(step_valid), 1);
    for (int c = 0; c < 300 && !got_done; c++) begin
      if (v.poke != 0 && c == 2) begin
        start = 1'b1;
        start_step = 9'h100;
        stop_step = 9'h0ff;
        incr = 8'd1;
        dwell = 16'd0;
      end else start = 1'b0;
      if (step_valid) begin
        if (np < v.n) chk($sformatf("v%0d pt%0d", k, np), $signed(step), v.pts[np]);
        if (np > 0) chk($sformatf("v%0d gap%0d", k, np), c - last, v.dw + 1);
        chk($sformatf("v%0d busy%0d", k, np), int'(busy), 1);
        lastpt = $signed(step);
        last = c;
        np++;
      end
      if (done) begin
        got_done = 1;
        chk($sformatf("v%0d done_gap", k), c - last, v.dw + 1);
        chk($sformatf("v%0d busy_at_done", k), int'(busy), 0);
        chk($sformatf("v%0d valid_at_done", k), int'(step_valid), 0);
      end else tick;
    end
    start = 1'b0;
    chk($sformatf("v%0d npoints", k), np, v.n);
    if (!got_done) chk($sformatf("v%0d timeout", k), 0, 1);
    tick;
    chk($sformatf("v%0d done_pulse", k), int'(done), 0);
    chk($sformatf("v%0d step_hold", k), $signed(step), lastpt);
  endtask

  initial begin
    int s;
    int cexp[7];
`ifdef SWEEP_TRIANGLE_EN
    vecs[0] = '{1, 7, 2, 3, 0, 7, '{1, 3, 5, 7, 5, 3, 1, 0, 0, 0}};
    vecs[1] = '{7, -7, 4, 0, 0, 9, '{7, 3, -1, -5, -7, -3, 1, 5, 7, 0}};
    vecs[2] = '{-256, 255, 255, 0, 0, 7, '{-256, -1, 254, 255, 0, -255, -256, 0, 0, 0}};
    vecs[3] = '{1, 3, 1, 0, 0, 5, '{1, 2, 3, 2, 1, 0, 0, 0, 0, 0}};
    vecs[6] = '{1, 7, 2, 3, 1, 7, '{1, 3, 5, 7, 5, 3, 1, 0, 0, 0}};
    cexp = '{1, 2, 3, 2, 1, 2, 3};
`else
    vecs[0] = '{1, 7, 2, 3, 0, 4, '{1, 3, 5, 7, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{7, -7, 4, 0, 0, 5, '{7, 3, -1, -5, -7, 0, 0, 0, 0, 0}};
    vecs[2] = '{-256, 255, 255, 0, 0, 4, '{-256, -1, 254, 255, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{1, 3, 1, 0, 0, 3, '{1, 2, 3, 0, 0, 0, 0, 0, 0, 0}};
    vecs[6] = '{1, 7, 2, 3, 1, 4, '{1, 3, 5, 7, 0, 0, 0, 0, 0, 0}};
    cexp = '{1, 2, 3, 1, 2, 3, 1};
`endif
    vecs[4] = '{4, 4, 3, 2, 0, 1, '{4, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[5] = '{5, 9, 0, 1, 0, 1, '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0}};

    repeat (2) @(posedge clk);
    #1;
    chk("reset step", $signed(step), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset valid", int'(step_valid), 0);
    chk("reset done", int'(done), 0);
    reset = 1'b0;
    tick;

    for (int k = 0; k < 7; k++) run_vec(k);

    start_step = 9'd1;
    stop_step = 9'd3;
    incr = 8'd1;
    dwell = 16'd0;
    continuous = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("cont pt%0d", i), $signed(step), cexp[i]);
      chk($sformatf("cont valid%0d", i), int'(step_valid), 1);
      tick;
    end
    s = $signed(step);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort valid", int'(step_valid), 0);
    chk("abort done", int'(done), 0);
    chk("abort step", $signed(step), s);
    repeat (3) begin
      tick;
      chk("abort no_done", int'(done), 0);
      chk("abort frozen", $signed(step), s);
    end
    continuous = 1'b0;

    start_step = 9'h1f0;
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort busy", int'(busy), 0);
    chk("start_abort valid", int'(step_valid), 0);
    chk("start_abort step", $signed(step), s);

    start_step = 9'd1;
    stop_step = 9'd7;
    incr = 8'd2;
    dwell = 16'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("pre_reset busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("async_reset step", $signed(step), 0);
    chk("async_reset busy", int'(busy), 0);
    chk("async_reset valid", int'(step_valid), 0);
    #1;
    reset = 1'b0;
    tick;
    chk("post_reset busy", int'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
